// File: rtl/pipe_out_block_fifo.sv
// -----------------------------------------------------------------------------
// pipe_out_block_fifo
//
// Circular buffer that sits in front of a block-throttled pipe-out endpoint.
// A local producer pushes 16-bit words in. The host endpoint pulls words out
// one per read strobe. pipe_out_ready is raised only while at least one full
// block (BLOCK_WORDS) is buffered. Words dropped on overflow are counted, and
// reads that hit an empty buffer set a sticky flag, so the host can check
// transfer integrity.
//
// Parameters
//   DEPTH_LOG2   log2 of the buffer depth in words (4..14)
//   BLOCK_WORDS  words per host block; pipe_out_ready threshold
//
// Ports
//   clk             single clock; all logic on the rising edge
//   reset           synchronous, active-high; clears all state except the RAM
//   src_write       producer write strobe, one word per cycle
//   src_data        producer word, sampled when src_write=1
//   pipe_out_read   endpoint read strobe, one word per cycle
//   pipe_out_data   registered read data, valid the cycle after an accepted read
//   pipe_out_ready  registered, high while level >= BLOCK_WORDS
//   level           registered count of buffered words, 0..2**DEPTH_LOG2
//   overflow_count  saturating count of dropped producer words
//   underflow       sticky, set by a read while empty
// -----------------------------------------------------------------------------
module pipe_out_block_fifo #(
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  src_write,
    input  logic [15:0]           src_data,
    input  logic                  pipe_out_read,
    output logic [15:0]           pipe_out_data,
    output logic                  pipe_out_ready,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           overflow_count,
    output logic                  underflow
);

    localparam int              DEPTH     = 1 << DEPTH_LOG2;
    localparam int              LW        = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0]   DEPTH_LVL = LW'(DEPTH);
    localparam logic [LW-1:0]   BLOCK_LVL = LW'(BLOCK_WORDS);

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    logic          is_empty;
    logic          is_full;
    logic          rd_accept;
    logic          wr_accept;
    logic          wr_drop;
    logic [LW-1:0] level_next;

    // NOTE: every signal is assigned on every path through always_comb, so no
    // latch can be inferred.
    always_comb begin
        is_empty   = (level == '0);
        is_full    = (level == DEPTH_LVL);
        // A read drains a slot on the same edge, so a full buffer still
        // accepts a simultaneous write. An empty buffer never bypasses a
        // write to the reader.
        rd_accept  = pipe_out_read && !is_empty;
        wr_accept  = src_write && (!is_full || rd_accept);
        wr_drop    = src_write && !wr_accept;
        level_next = level + LW'(wr_accept) - LW'(rd_accept);
    end

    // NOTE: the RAM is deliberately left out of reset. Its contents are
    // unreachable until rewritten, and leaving it unreset lets it map onto
    // block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= src_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. When the
    // buffer is full, wr_ptr == rd_ptr, and the read below must see the
    // old word that is being replaced on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            pipe_out_data  <= 16'h0000;
            pipe_out_ready <= 1'b0;
            overflow_count <= 16'h0000;
            underflow      <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end

            if (wr_drop && overflow_count != 16'hFFFF) begin
                overflow_count <= overflow_count + 16'd1;
            end

            if (rd_accept) begin
                pipe_out_data <= mem[rd_ptr];
                rd_ptr        <= rd_ptr + DEPTH_LOG2'(1);
            end else if (pipe_out_read) begin
                pipe_out_data <= 16'h0000;
                underflow     <= 1'b1;
            end

            level          <= level_next;
            // Registered from level_next so that ready tracks the level
            // register on every cycle.
            pipe_out_ready <= (level_next >= BLOCK_LVL);
        end
    end

endmodule

// File: tb/tb_pipe_out_block_fifo.sv
// -----------------------------------------------------------------------------
// tb_pipe_out_block_fifo
//
// Bench for pipe_out_block_fifo with default parameters. A queue-based model
// holds the buffered words. Every cycle after the first reset, the DUT outputs
// are compared against this model. Directed phases pin specific literal values.
// Randomized phases exercise wrap, overflow and underflow.
// -----------------------------------------------------------------------------
module tb_pipe_out_block_fifo;

    localparam int DEPTH_LOG2  = 10;
    localparam int BLOCK_WORDS = 256;
    localparam int DEPTH       = 1 << DEPTH_LOG2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                src_write = 1'b0;
    logic [15:0]         src_data = 16'h0000;
    logic                pipe_out_read = 1'b0;
    logic [15:0]         pipe_out_data;
    logic                pipe_out_ready;
    logic [DEPTH_LOG2:0] level;
    logic [15:0]         overflow_count;
    logic                underflow;

    int n_chk = 0;
    int n_err = 0;

    pipe_out_block_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .BLOCK_WORDS(BLOCK_WORDS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .src_write     (src_write),
        .src_data      (src_data),
        .pipe_out_read (pipe_out_read),
        .pipe_out_data (pipe_out_data),
        .pipe_out_ready(pipe_out_ready),
        .level         (level),
        .overflow_count(overflow_count),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_q[$];
    logic [15:0] m_data = 16'h0000;
    logic [15:0] m_ovf  = 16'h0000;
    logic        m_uf   = 1'b0;
    bit          armed  = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_data = 16'h0000;
            m_ovf  = 16'h0000;
            m_uf   = 1'b0;
            armed  = 1'b1;
        end else if (armed) begin
            // Read first: a read frees a slot for a same-cycle write, and an
            // empty buffer underflows even if a write arrives together with it.
            if (pipe_out_read) begin
                if (m_q.size() > 0) begin
                    m_data = m_q.pop_front();
                end else begin
                    m_data = 16'h0000;
                    m_uf   = 1'b1;
                end
            end
            if (src_write) begin
                if (m_q.size() < DEPTH) m_q.push_back(src_data);
                else if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
            end
        end
        if (armed) begin
            #1;
            check("model_level", 32'(level), 32'(m_q.size()));
            check("model_ready", 32'(pipe_out_ready), 32'(m_q.size() >= BLOCK_WORDS));
            check("model_data", 32'(pipe_out_data), 32'(m_data));
            check("model_ovf", 32'(overflow_count), 32'(m_ovf));
            check("model_uf", 32'(underflow), 32'(m_uf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic wr, input logic [15:0] d, input logic rd);
        src_write     = wr;
        src_data      = d;
        pipe_out_read = rd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 16'h0000, 1'b0);
        reset = 1'b0;
    endtask

    task automatic random_phase(input int cycles, input int wr_pct, input int rd_pct);
        for (int c = 0; c < cycles; c++) begin
            step(($urandom % 100) < wr_pct, 16'($urandom), ($urandom % 100) < rd_pct);
        end
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        do_reset();
        check("rst_level", 32'(level), 32'd0);
        check("rst_ready", 32'(pipe_out_ready), 32'd0);
        check("rst_data", 32'(pipe_out_data), 32'h0000);
        check("rst_ovf", 32'(overflow_count), 32'd0);
        check("rst_uf", 32'(underflow), 32'd0);

        // Threshold crossing
        for (int i = 1; i <= 255; i++) step(1'b1, 16'(i), 1'b0);
        check("lvl255", 32'(level), 32'd255);
        check("rdy255", 32'(pipe_out_ready), 32'd0);
        step(1'b1, 16'h0100, 1'b0);
        check("lvl256", 32'(level), 32'd256);
        check("rdy256", 32'(pipe_out_ready), 32'd1);

        // One block read out, one-cycle latency
        for (int i = 1; i <= 256; i++) begin
            step(1'b0, 16'h0000, 1'b1);
            check("block_data", 32'(pipe_out_data), 32'(i));
        end
        check("drained_lvl", 32'(level), 32'd0);
        check("drained_rdy", 32'(pipe_out_ready), 32'd0);
        check("drained_uf", 32'(underflow), 32'd0);

        // Fill to full, then overflow by 5
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(16'h1000 + i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'hDEAD, 1'b0);
        check("full_lvl", 32'(level), 32'd1024);
        check("full_ovf", 32'(overflow_count), 32'd5);
        step(1'b0, 16'h0000, 1'b1);
        check("first_after_ovf", 32'(pipe_out_data), 32'h1000);
        step(1'b1, 16'h2000, 1'b0);
        check("refull_lvl", 32'(level), 32'd1024);

        // Full with simultaneous read and write: nothing dropped
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 16'(16'h3000 + k), 1'b1);
            check("fullrw_data", 32'(pipe_out_data), 32'(16'h1001 + k));
            check("fullrw_lvl", 32'(level), 32'd1024);
            check("fullrw_ovf", 32'(overflow_count), 32'd5);
        end

        // Drain completely, then hit the empty-read case with a write
        for (int i = 0; i < DEPTH; i++) step(1'b0, 16'h0000, 1'b1);
        check("empty_lvl", 32'(level), 32'd0);
        check("empty_uf", 32'(underflow), 32'd0);
        step(1'b1, 16'hBEEF, 1'b1);
        check("uf_data", 32'(pipe_out_data), 32'h0000);
        check("uf_flag", 32'(underflow), 32'd1);
        check("uf_lvl", 32'(level), 32'd1);
        step(1'b0, 16'h0000, 1'b1);
        check("beef", 32'(pipe_out_data), 32'hBEEF);

        // Reset mid-transfer discards everything
        do_reset();
        for (int i = 0; i < 600; i++) step(1'b1, 16'($urandom | 1), 1'b0);
        for (int i = 0; i < 300; i++) step(1'b0, 16'h0000, 1'b1);
        do_reset();
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_ready", 32'(pipe_out_ready), 32'd0);
        check("mid_rst_ovf", 32'(overflow_count), 32'd0);
        check("mid_rst_uf", 32'(underflow), 32'd0);
        check("mid_rst_data", 32'(pipe_out_data), 32'h0000);

        // Pointer wrap: 2000 words through with random strobes, then drain
        begin
            int written = 0;
            for (int c = 0; c < 6000 && written < 2000; c++) begin
                logic wr;
                wr = ($urandom % 4) != 0;
                step(wr, 16'(written), ($urandom % 3) != 0);
                if (wr) written++;
            end
        end
        for (int i = 0; i < 1200; i++) step(1'b0, 16'h0000, 1'b1);

        // Random stress: write-heavy to force drops, then read-heavy
        do_reset();
        random_phase(2500, 90, 20);
        random_phase(1500, 30, 90);
        random_phase(1000, 50, 50);

        step(1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
